// File: rtl/icape_regs.sv
// ICAPE2 configuration register map and warm-boot sequencer state encoding.
// Shared by the bridge, the warm-boot master and the software header generator.
package icape_regs;

  localparam logic [4:0]  ICAP_CMD     = 5'h04;
  localparam logic [4:0]  ICAP_WBSTAR  = 5'h10;
  localparam logic [4:0]  ICAP_BOOTSTS = 5'h16;

  localparam logic [31:0] CMD_IPROG    = 32'h0000_000F;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_WBSTAR = 2'd1,
    ST_WR_IPROG  = 2'd2,
    ST_RD_STAT   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/icape_warmboot.sv
// Wishbone master that sequences the ICAPE2 bridge for a warm boot (WBSTAR write
// then IPROG) or a BOOTSTS readback, with a per-transaction ack timeout.
module icape_warmboot
  import icape_regs::*;
#(
  parameter int TIMEOUT_LG = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_boot_req,
  input  logic [31:0] i_boot_addr,
  input  logic        i_status_req,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_bootsts,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic [31:0] i_wb_data
);

  wb_state_t             state, state_n;
  logic [TIMEOUT_LG-1:0] cnt, cnt_n, cnt_inc;
  logic                  expire;
  logic                  cyc_n, stb_n, we_n, busy_n, done_n, err_n;
  logic [4:0]            addr_n;
  logic [31:0]           data_n, bootsts_n;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_bootsts <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      o_wb_cyc  <= cyc_n;
      o_wb_stb  <= stb_n;
      o_wb_we   <= we_n;
      o_wb_addr <= addr_n;
      o_wb_data <= data_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
      o_err     <= err_n;
      o_bootsts <= bootsts_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cyc_n     = o_wb_cyc;
    stb_n     = o_wb_stb;
    we_n      = o_wb_we;
    addr_n    = o_wb_addr;
    data_n    = o_wb_data;
    busy_n    = o_busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    bootsts_n = o_bootsts;
    cnt_inc   = cnt + 1'b1;
    // Abort on the cycle the counter would reach all-ones, so cyc is high for
    // exactly 2^TIMEOUT_LG-1 cycles when no ack ever comes.
    expire    = &cnt_inc;

    case (state)
      ST_IDLE: begin
        // The cycle carrying o_done is still busy; requests open up one cycle later.
        if (o_busy) begin
          busy_n = 1'b0;
        end else if (i_boot_req) begin
          state_n = ST_WR_WBSTAR;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = 1'b1;
          addr_n  = ICAP_WBSTAR;
          data_n  = i_boot_addr;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end else if (i_status_req) begin
          state_n = ST_RD_STAT;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = 1'b0;
          addr_n  = ICAP_BOOTSTS;
          data_n  = '0;
          busy_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      default: begin
        if (o_wb_stb && !i_wb_stall) stb_n = 1'b0;
        if (i_wb_ack) begin
          if (state == ST_WR_WBSTAR) begin
            // cyc stays up across the pair so IPROG follows WBSTAR in one bus cycle.
            state_n = ST_WR_IPROG;
            stb_n   = 1'b1;
            we_n    = 1'b1;
            addr_n  = ICAP_CMD;
            data_n  = CMD_IPROG;
            cnt_n   = '0;
          end else begin
            if (state == ST_RD_STAT) bootsts_n = i_wb_data;
            state_n = ST_IDLE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt_inc;
          if (expire) begin
            state_n = ST_IDLE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            done_n  = 1'b1;
            // The device may reconfigure before acking IPROG, so that is not a failure.
            err_n   = (state != ST_WR_IPROG);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_icape_warmboot.sv
// Bench for icape_warmboot: two instances (default and 4-bit timeout) driven by a
// latency-programmable slave, checked each cycle against a timeline model.
module tb_icape_warmboot;

  localparam int MAXC = 4096;
  localparam int T0   = 1023;
  localparam int T1   = 15;

  typedef struct {int s; int a;} txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, boot_req, status_req;
  logic [1:0]       busy, done, err, wb_cyc, wb_stb, wb_we;
  logic [1:0]       stall = '0, sack = '0, xack = '0, ack;
  logic [1:0][31:0] boot_addr, bootsts, wb_wdat, rd_val;
  logic [1:0][4:0]  wb_addr;

  assign ack = sack | xack;

  icape_warmboot u_dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_boot_req(boot_req[0]), .i_boot_addr(boot_addr[0]),
    .i_status_req(status_req[0]), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]),
    .o_bootsts(bootsts[0]), .o_wb_cyc(wb_cyc[0]), .o_wb_stb(wb_stb[0]), .o_wb_we(wb_we[0]),
    .o_wb_addr(wb_addr[0]), .o_wb_data(wb_wdat[0]), .i_wb_ack(ack[0]),
    .i_wb_stall(stall[0]), .i_wb_data(rd_val[0]));

  icape_warmboot #(.TIMEOUT_LG(4)) u_dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_boot_req(boot_req[1]), .i_boot_addr(boot_addr[1]),
    .i_status_req(status_req[1]), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]),
    .o_bootsts(bootsts[1]), .o_wb_cyc(wb_cyc[1]), .o_wb_stb(wb_stb[1]), .o_wb_we(wb_we[1]),
    .o_wb_addr(wb_addr[1]), .o_wb_data(wb_wdat[1]), .i_wb_ack(ack[1]),
    .i_wb_stall(stall[1]), .i_wb_data(rd_val[1]));

  // Expected per-cycle outputs, indexed [dut][cycle]; untouched cycles mean idle.
  bit        e_busy [2][MAXC];
  bit        e_cyc  [2][MAXC];
  bit        e_stb  [2][MAXC];
  bit        e_done [2][MAXC];
  bit        e_err  [2][MAXC];
  bit        e_we   [2][MAXC];
  bit [4:0]  e_addr [2][MAXC];
  bit [31:0] e_data [2][MAXC];
  bit [31:0] e_bs   [2][MAXC];

  int vectors = 0, miscompares = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  bit          act [2];
  int          kc [2], cs [2], ca [2];
  txn_t        q0 [$], q1 [$];
  logic [37:0] log0 [$], log1 [$];
  int          done_cnt [2], last_done [2];
  bit          last_err [2];

  task automatic chk(input string nm, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h, want %h", nm, k, cyc_cnt, act_v, exp_v);
    end
  endtask

  // Compare, then play the slave for this cycle, then log accepted strobes.
  always @(negedge clk) begin
    int c;
    c = cyc_cnt;
    for (int k = 0; k < 2; k++) begin
      if (!rst[k] && c < MAXC) begin
        chk("busy", k, 32'(busy[k]), 32'(e_busy[k][c]));
        chk("cyc", k, 32'(wb_cyc[k]), 32'(e_cyc[k][c]));
        chk("stb", k, 32'(wb_stb[k]), 32'(e_stb[k][c]));
        chk("done", k, 32'(done[k]), 32'(e_done[k][c]));
        chk("err", k, 32'(err[k]), 32'(e_err[k][c]));
        chk("bootsts", k, bootsts[k], e_bs[k][c]);
        if (e_stb[k][c]) begin
          chk("addr", k, 32'(wb_addr[k]), 32'(e_addr[k][c]));
          chk("we", k, 32'(wb_we[k]), 32'(e_we[k][c]));
          chk("wdata", k, wb_wdat[k], e_data[k][c]);
        end
      end
      if (done[k] === 1'b1) begin
        done_cnt[k]++;
        last_done[k] = c;
        last_err[k]  = err[k];
      end
      if (rst[k] || !wb_cyc[k]) begin
        act[k] = 1'b0; stall[k] = 1'b0; sack[k] = 1'b0;
      end else begin
        if (!act[k] && wb_stb[k]) begin
          txn_t t;
          t.s = 0; t.a = 1_000_000;
          if (k == 0 && q0.size() > 0) t = q0.pop_front();
          else if (k == 1 && q1.size() > 0) t = q1.pop_front();
          cs[k] = t.s; ca[k] = t.a; kc[k] = 0; act[k] = 1'b1;
        end
        if (act[k]) begin
          stall[k] = (kc[k] < cs[k]);
          sack[k]  = (kc[k] == ca[k]);
          if (sack[k]) act[k] = 1'b0;
          kc[k]++;
        end else begin
          stall[k] = 1'b0; sack[k] = 1'b0;
        end
        if (wb_stb[k] && !stall[k]) begin
          if (k == 0) log0.push_back({wb_addr[k], wb_we[k], wb_wdat[k]});
          else        log1.push_back({wb_addr[k], wb_we[k], wb_wdat[k]});
        end
      end
    end
  end

  task automatic mark_stb(input int k, input int t, input int s, input int d,
                          input bit [4:0] a, input bit we, input bit [31:0] dat);
    for (int c = t; c <= t + s && c < d; c++) begin
      e_stb[k][c] = 1'b1; e_addr[k][c] = a; e_we[k][c] = we; e_data[k][c] = dat;
    end
  endtask

  // kind: 0 status, 1 boot, 2 both at once. Called at the negedge of the request cycle.
  task automatic start_seq(input int k, input int kind, input bit [31:0] addr,
                           input int s1, input int a1, input int s2, input int a2,
                           input bit [31:0] rdv, output int d);
    int   n, tmo, t1, t2;
    bit   isboot, ok1, ok2, er;
    txn_t tx;
    n = cyc_cnt;
    tmo = (k == 0) ? T0 : T1;
    isboot = (kind != 0);
    rd_val[k] = rdv;
    if (isboot) begin boot_req[k] = 1'b1; boot_addr[k] = addr; end
    if (kind != 1) status_req[k] = 1'b1;
    t1 = n + 1; ok1 = (a1 < tmo); er = 1'b0; t2 = 0; ok2 = 1'b0;
    if (!ok1) begin d = t1 + tmo; er = 1'b1; end
    else if (!isboot) d = t1 + a1 + 1;
    else begin
      t2 = t1 + a1 + 1; ok2 = (a2 < tmo);
      d = ok2 ? t2 + a2 + 1 : t2 + tmo;
    end
    if (d + 8 >= MAXC) begin
      $display("FAIL cycle_budget dut%0d: end cycle %0d, limit %0d", k, d, MAXC);
      $fatal(1);
    end
    tx.s = s1; tx.a = a1;
    if (k == 0) q0.push_back(tx); else q1.push_back(tx);
    if (isboot && ok1) begin
      tx.s = s2; tx.a = a2;
      if (k == 0) q0.push_back(tx); else q1.push_back(tx);
    end
    for (int c = n + 1; c <= d; c++) e_busy[k][c] = 1'b1;
    for (int c = t1; c < d; c++) e_cyc[k][c] = 1'b1;
    e_done[k][d] = 1'b1;
    e_err[k][d]  = er;
    if (isboot) mark_stb(k, t1, s1, d, 5'h10, 1'b1, addr);
    else        mark_stb(k, t1, s1, d, 5'h16, 1'b0, 32'h0);
    if (isboot && ok1) mark_stb(k, t2, s2, d, 5'h04, 1'b1, 32'h0000_000F);
    if (!isboot && ok1) for (int c = d; c < MAXC; c++) e_bs[k][c] = rdv;
  endtask

  // Runs to the first cycle a new request may be accepted, optionally
  // throwing requests at the busy block meanwhile.
  task automatic finish_seq(input int k, input int d, input bit junk);
    forever begin
      @(negedge clk);
      if (cyc_cnt > d) break;
      boot_req[k]   = junk ? ($urandom_range(0, 3) == 0) : 1'b0;
      status_req[k] = junk ? ($urandom_range(0, 3) == 0) : 1'b0;
      boot_addr[k]  = $urandom;
    end
    boot_req[k] = 1'b0; status_req[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int g);
    repeat (g) begin
      xack[k] = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    xack[k] = 1'b0;
  endtask

  task automatic run(input int k, input int kind, input bit [31:0] addr, input int s1, input int a1,
                     input int s2, input int a2, input bit [31:0] rdv, input bit junk);
    int d;
    start_seq(k, kind, addr, s1, a1, s2, a2, rdv, d);
    finish_seq(k, d, junk);
  endtask

  task automatic rand_loop(input int k, input int spread);
    repeat (40) begin
      int s1, s2;
      s1 = $urandom_range(0, 3); s2 = $urandom_range(0, 3);
      run(k, $urandom_range(0, 2), $urandom, s1, s1 + $urandom_range(0, spread),
          s2, s2 + $urandom_range(0, spread), $urandom, $urandom_range(0, 1) == 1);
      idle(k, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors", vectors);
    $fatal(1);
  end

  initial begin
    int n, d, lb, dc;
    rst = 2'b11; boot_req = '0; status_req = '0; boot_addr = '0; rd_val = '0;
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_cyc", k, 32'(wb_cyc[k]), 0);   chk("rst_stb", k, 32'(wb_stb[k]), 0);
      chk("rst_we", k, 32'(wb_we[k]), 0);     chk("rst_busy", k, 32'(busy[k]), 0);
      chk("rst_done", k, 32'(done[k]), 0);    chk("rst_err", k, 32'(err[k]), 0);
      chk("rst_addr", k, 32'(wb_addr[k]), 0); chk("rst_data", k, wb_wdat[k], 0);
      chk("rst_bootsts", k, bootsts[k], 0);
    end
    @(posedge clk); #2 rst = 2'b00;
    @(negedge clk);

    // Boot to 0x0040_0000, 3 stall cycles and ack 200 cycles after each strobe.
    n = cyc_cnt; lb = log0.size(); dc = done_cnt[0];
    run(0, 1, 32'h0040_0000, 3, 200, 3, 200, 32'h0, 1'b0);
    chk("boot_nwr", 0, log0.size() - lb, 2);
    chk("boot_wr0_addr", 0, 32'(log0[lb][37:33]), 32'h10);
    chk("boot_wr0_data", 0, log0[lb][31:0], 32'h0040_0000);
    chk("boot_wr1_addr", 0, 32'(log0[lb+1][37:33]), 32'h04);
    chk("boot_wr1_data", 0, log0[lb+1][31:0], 32'h0000_000F);
    chk("boot_ndone", 0, done_cnt[0] - dc, 1);
    chk("boot_done_at", 0, last_done[0] - n, 403);
    chk("boot_err", 0, 32'(last_err[0]), 0);
    idle(0, 2);

    run(0, 0, 32'h0, 1, 2, 0, 0, 32'h0000_0101, 1'b0);
    chk("stat_bootsts", 0, bootsts[0], 32'h0000_0101);

    // Both requests together, then a status request mid-boot.
    lb = log0.size();
    start_seq(0, 2, 32'h0123_4567, 0, 1, 2, 3, 32'hDEAD_BEEF, d);
    @(negedge clk);
    boot_req[0] = 1'b0; status_req[0] = 1'b1;
    finish_seq(0, d, 1'b0);
    chk("both_nwr", 0, log0.size() - lb, 2);
    chk("both_wr1_addr", 0, 32'(log0[lb+1][37:33]), 32'h04);
    chk("both_bootsts", 0, bootsts[0], 32'h0000_0101);

    // Back-to-back status on the first idle cycle.
    n = cyc_cnt;
    start_seq(0, 0, 32'h0, 0, 0, 0, 0, 32'hCAFE_0001, d);
    @(negedge clk);
    status_req[0] = 1'b0;
    chk("b2b_stb", 0, 32'(wb_stb[0]), 1);
    finish_seq(0, d, 1'b0);
    chk("b2b_done_at", 0, last_done[0] - n, 2);

    // Reset while WBSTAR is held off by stall.
    dc = done_cnt[0];
    start_seq(0, 1, 32'h1234_5678, 20, 30, 0, 0, 32'h0, d);
    @(negedge clk); boot_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst[0] = 1'b1;
    q0.delete();
    for (int c = cyc_cnt; c < MAXC; c++) begin
      e_busy[0][c] = 0; e_cyc[0][c] = 0; e_stb[0][c] = 0; e_done[0][c] = 0;
      e_err[0][c] = 0; e_bs[0][c] = 0;
    end
    #1;
    chk("mid_rst_cyc", 0, 32'(wb_cyc[0]), 0);
    chk("mid_rst_stb", 0, 32'(wb_stb[0]), 0);
    chk("mid_rst_busy", 0, 32'(busy[0]), 0);
    @(posedge clk); #2 rst[0] = 1'b0;
    @(negedge clk); xack[0] = 1'b1;
    @(negedge clk); xack[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_ack_ndone", 0, done_cnt[0] - dc, 0);

    rand_loop(0, 6);

    // 4-bit timeout instance: 15 cycles of cyc without ack aborts.
    n = cyc_cnt;
    run(1, 0, 32'h0, 0, 1000, 0, 0, 32'h1111_2222, 1'b0);
    chk("tmo_stat_done_at", 1, last_done[1] - n, 16);
    chk("tmo_stat_err", 1, 32'(last_err[1]), 1);
    chk("tmo_stat_bootsts", 1, bootsts[1], 32'h0);
    idle(1, 1);
    run(1, 0, 32'h0, 0, 14, 0, 0, 32'h0000_0055, 1'b0);
    chk("edge14_err", 1, 32'(last_err[1]), 0);
    chk("edge14_bootsts", 1, bootsts[1], 32'h0000_0055);
    n = cyc_cnt;
    run(1, 0, 32'h0, 0, 15, 0, 0, 32'h0000_0077, 1'b0);
    chk("edge15_done_at", 1, last_done[1] - n, 16);
    chk("edge15_err", 1, 32'(last_err[1]), 1);
    chk("edge15_bootsts", 1, bootsts[1], 32'h0000_0055);

    n = cyc_cnt; lb = log1.size();
    run(1, 1, 32'h00A0_0000, 0, 2, 0, 1000, 32'h0, 1'b0);
    chk("tmo_iprog_done_at", 1, last_done[1] - n, 19);
    chk("tmo_iprog_err", 1, 32'(last_err[1]), 0);
    chk("tmo_iprog_nwr", 1, log1.size() - lb, 2);

    rand_loop(1, 16);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
